reg_bank_clr: RTL
=================

// Module: reg_bank_clr
// PURPOSE
// - Parametrised successor of the CPU register stack: 2 registered read ports, 1 write port, DEPTH x WORD_SIZE.
// - Adds write-to-read bypass, read-valid strobe and a sequenced bank-clear engine (one entry per cycle, busy flag).
// - Sits between decode (register numbers) and ALU/writeback; replaces the single-cycle reset_enable wipe.
// PARAMETERS
// - WORD_SIZE  16  data width of each entry
// - ADDR_SIZE  4   register-number width; DEPTH = 1<<ADDR_SIZE (16 by default)
// PORTS
// - clk       in   1          clock, all state on rising edge
// - rst_n     in   1          asynchronous active-low reset
// - rd_en     in   1          read request, both ports
// - rd_addr1  in   ADDR_SIZE  read port 1 register number
// - rd_addr2  in   ADDR_SIZE  read port 2 register number
// - rd_data1  out  WORD_SIZE  port 1 data, registered
// - rd_data2  out  WORD_SIZE  port 2 data, registered
// - rd_valid  out  1          1-cycle strobe: rd_data1/2 updated this cycle
// - wr_en     in   1          write request
// - wr_addr   in   ADDR_SIZE  write register number
// - wr_data   in   WORD_SIZE  write data
// - clr_req   in   1          start bank clear (1-cycle pulse or level; sampled only in IDLE)
// - busy      out  1          clear in progress
// BEHAVIOUR
// - Reset (rst_n=0, async): all entries 0, rd_data1/2=0, rd_valid=0, busy=0, FSM=IDLE, clear ptr=0.
// - Write: wr_en=1 in IDLE -> entry[wr_addr] <= wr_data at that edge.
// - Read: rd_en=1 in IDLE at edge N -> rd_data1/2 loaded at edge N, rd_valid=1 for cycle after N (1-cycle latency).
//   rd_en=0 -> rd_data1/2 hold last value, rd_valid=0.
// - Bypass: rd_en and wr_en same edge, rd_addrX==wr_addr -> rd_dataX = wr_data (new value), per port independently.
// - Both ports may read same address; result identical.
// - FSM IDLE: clr_req=1 -> CLEAR, ptr=0. Reads/writes on that same edge are still served normally.
// - FSM CLEAR: each edge entry[ptr] <= 0, ptr++; after ptr==DEPTH-1 cleared -> IDLE, ptr=0.
//   busy=1 exactly DEPTH cycles (from edge after clr_req sampled to entry DEPTH-1 cleared).
// - During CLEAR: wr_en dropped (no write, no queue); rd_en ignored (rd_valid=0, rd_data hold); clr_req ignored.
// - Write + clr_req same IDLE edge: write lands, then cleared by sequence.
// - ptr is ADDR_SIZE bits; terminal detect on all-ones, no wrap-around into second pass.
// - rst_n low mid-clear: abort immediately, reset values as above; no resumption.
// - All addresses valid (DEPTH = 2^ADDR_SIZE); no out-of-range case.
// CONFIGURATION
// - ZERO_REG_EN defined: entry 0 hard-wired zero; writes to addr 0 discarded; reads of addr 0 return 0;
//   bypass not applied for addr 0; clear sequence unchanged (still DEPTH cycles).
// - ZERO_REG_EN undefined: entry 0 ordinary storage, same rules as all others.
// TESTING (WORD_SIZE=16, ADDR_SIZE=4)
// - Reset then rd_en, addr1=9, addr2=10 -> next cycle rd_valid=1, rd_data1=0x0000, rd_data2=0x0000, busy=0.
// - wr 9=0xAF53; next cycle rd 9,10 -> rd_data1=0xAF53, rd_data2=0x0000, rd_valid 1 cycle only.
// - Same edge wr 10=0x1234 and rd addr1=10, addr2=9 -> rd_data1=0x1234 (bypass), rd_data2=0xAF53.
// - Preload 9,15; clr_req pulse -> busy=1 for 16 cycles; wr 3=0x5555 and rd_en during busy -> dropped, rd_valid=0;
//   after busy=0 read 9,15 then 3 -> all 0x0000.
// - clr_req, then rst_n=0 at 5th busy cycle -> busy=0, rd_data=0 immediately (async); release, read 15 -> 0x0000, busy stays 0.
// - wr 0=0xFFFF, rd 0 -> 0x0000 with ZERO_REG_EN, 0xFFFF without; same-edge wr/rd of addr 0 follows same rule.

Source files
------------

// File: rtl/reg_bank_clr_if.sv
// reg_bank_clr_if: read/write/clear bus between decode/writeback (master) and the register bank (slave)
//   rd_en, rd_addr1/2   -> read request for both ports
//   rd_data1/2, rd_valid <- registered read data and its 1-cycle strobe
//   wr_en, wr_addr, wr_data -> write request
//   clr_req -> start bank clear; busy <- clear in progress
interface reg_bank_clr_if #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 4
);
  logic                 rd_en;
  logic [ADDR_SIZE-1:0] rd_addr1;
  logic [ADDR_SIZE-1:0] rd_addr2;
  logic [WORD_SIZE-1:0] rd_data1;
  logic [WORD_SIZE-1:0] rd_data2;
  logic                 rd_valid;
  logic                 wr_en;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [WORD_SIZE-1:0] wr_data;
  logic                 clr_req;
  logic                 busy;
  modport master (
    output rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req,
    input  rd_data1, rd_data2, rd_valid, busy
  );
  modport slave (
    input  rd_en, rd_addr1, rd_addr2, wr_en, wr_addr, wr_data, clr_req,
    output rd_data1, rd_data2, rd_valid, busy
  );
endinterface

// File: rtl/reg_bank_clr.sv
// reg_bank_clr: 2-read/1-write register bank with write-to-read bypass and sequenced bank clear
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : reg_bank_clr_if.slave (read/write/clear request, registered read data, rd_valid, busy)
// Optional feature macro ZERO_REG_EN: entry 0 reads as zero, writes to it are discarded.
module reg_bank_clr #(
  parameter int WORD_SIZE = 16,
  parameter int ADDR_SIZE = 4
) (
  input logic           clk,
  input logic           rst_n,
  reg_bank_clr_if.slave bus
);
  localparam int DEPTH = 1 << ADDR_SIZE;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t               state_q;
  logic [ADDR_SIZE-1:0] ptr_q;
  logic [WORD_SIZE-1:0] mem_q [DEPTH];
  logic [WORD_SIZE-1:0] rd_data1_q, rd_data1_d;
  logic [WORD_SIZE-1:0] rd_data2_q, rd_data2_d;
  logic                 rd_valid_q;
  logic                 idle, rd_ok, wr_ok;
  assign idle  = state_q == IDLE;
  assign rd_ok = idle && bus.rd_en;
`ifdef ZERO_REG_EN
  // entry 0 is never written, so it stays at its reset/clear value of zero and
  // the bypass below never fires for address 0
  assign wr_ok = idle && bus.wr_en && |bus.wr_addr;
`else
  assign wr_ok = idle && bus.wr_en;
`endif
  always_comb begin
    rd_data1_d = !rd_ok ? rd_data1_q : (wr_ok && bus.rd_addr1 == bus.wr_addr) ? bus.wr_data : mem_q[bus.rd_addr1];
    rd_data2_d = !rd_ok ? rd_data2_q : (wr_ok && bus.rd_addr2 == bus.wr_addr) ? bus.wr_data : mem_q[bus.rd_addr2];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      rd_data1_q <= '0;
      rd_data2_q <= '0;
      rd_valid_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      rd_data1_q <= rd_data1_d;
      rd_data2_q <= rd_data2_d;
      rd_valid_q <= rd_ok;
      if (wr_ok) mem_q[bus.wr_addr] <= bus.wr_data;
      case (state_q)
        IDLE: begin
          ptr_q <= '0;
          if (bus.clr_req) state_q <= CLEAR;
        end
        default: begin
          mem_q[ptr_q] <= '0;
          // ptr wraps to 0 on the terminal entry, ready for the next clear
          ptr_q <= ptr_q + 1'b1;
          if (&ptr_q) state_q <= IDLE;
        end
      endcase
    end
  end
  assign bus.rd_data1 = rd_data1_q;
  assign bus.rd_data2 = rd_data2_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.busy     = state_q == CLEAR;
endmodule
